// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 9;
  localparam int PERF_W      = 16;

  typedef enum logic {
    FREE       = 1'b0,
    AUX_LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_AUX  = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arb_perf.sv
// rtl/dmem_arb_perf.sv - free-running conflict / forced-grant event counters (wrap mod 2^16)
module dmem_arb_perf
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_conflict,
  input  logic              i_forced,
  output logic [PERF_W-1:0] o_conflicts,
  output logic [PERF_W-1:0] o_forced
);

  logic [PERF_W-1:0] r_conflicts;
  logic [PERF_W-1:0] r_forced;

  // Count each qualifying cycle; wrap naturally on overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflicts <= '0;
      r_forced    <= '0;
    end else begin
      if (i_conflict) r_conflicts <= r_conflicts + 1'b1;
      if (i_forced)   r_forced    <= r_forced + 1'b1;
    end
  end

  assign o_conflicts = r_conflicts;
  assign o_forced    = r_forced;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/aux data-memory arbiter; perf counters built only with DMEM_ARB_PERF_EN
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic              core_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic              aux_lock,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [15:0]       perf_conflicts,
  output logic [15:0]       perf_forced
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_e r_state;
  logic [3:0] r_wait_cnt;
  logic       r_rd_pend;
  owner_e     r_rd_owner;

  logic w_locked_hold;
  logic w_forced;
  logic w_core_gnt;
  logic w_aux_gnt;
  logic w_we;

  // Locked ownership persists only while aux keeps aux_lock high; a dropped
  // lock falls straight through to normal arbitration in the same cycle.
  assign w_locked_hold = (r_state == AUX_LOCKED) && aux_lock;
  assign w_forced      = ~w_locked_hold && aux_req && (r_wait_cnt == MAX_WAIT_C);
  assign w_core_gnt    = ~reset & ~w_locked_hold & ~w_forced & core_req;
  assign w_aux_gnt     = ~reset & aux_req & (w_locked_hold | w_forced | ~core_req);

  assign core_gnt   = w_core_gnt;
  assign aux_gnt    = w_aux_gnt;
  assign core_stall = core_req & ~w_core_gnt;

  assign w_we        = w_core_gnt ? core_we : aux_we;
  assign mem_wr      = (w_core_gnt | w_aux_gnt) & w_we;
  assign mem_rd      = (w_core_gnt | w_aux_gnt) & ~w_we;
  assign mem_addr    = w_core_gnt ? core_addr  : (w_aux_gnt ? aux_addr  : '0);
  assign mem_wr_data = w_core_gnt ? core_wdata : (w_aux_gnt ? aux_wdata : '0);

  // Read data arrives one cycle after the strobe; steer it to whoever issued it
  assign rdata       = mem_rd_data;
  assign core_rvalid = r_rd_pend & (r_rd_owner == OWN_CORE);
  assign aux_rvalid  = r_rd_pend & (r_rd_owner == OWN_AUX);

  // Lock state, aux starvation counter and read-return owner tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= FREE;
      r_wait_cnt <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= OWN_CORE;
    end else begin
      r_state <= (aux_lock && (w_locked_hold || w_aux_gnt)) ? AUX_LOCKED : FREE;
      if (aux_req && !w_aux_gnt) begin
        if (r_wait_cnt != MAX_WAIT_C) r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      r_rd_pend  <= (w_core_gnt & ~core_we) | (w_aux_gnt & ~aux_we);
      r_rd_owner <= w_aux_gnt ? OWN_AUX : OWN_CORE;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic w_conflict;
  assign w_conflict = core_req & aux_req;

  dmem_arb_perf u_perf (
    .clk         (clk),
    .reset       (reset),
    .i_conflict  (w_conflict),
    .i_forced    (w_forced),
    .o_conflicts (perf_conflicts),
    .o_forced    (perf_forced)
  );
`else
  assign perf_conflicts = '0;
  assign perf_forced    = '0;
`endif

endmodule
